def_test_stim_checker: RTL
==========================

Name: def_test_stim_checker

Overview:
- Self-checking stimulus/response stage placed around the pin-test design: drives its single data input and consumes its three outputs.
- Outputs consumed: inverted data, tie-high pin, off-grid tie-high pin.
- Generates an LFSR pattern, waits a settle interval, and checks out == ~in and both tie pins == 1.
- Reports error count, first failing vector index, and a pass/done flag. Used for post-layout gate-level simulation of pin and tie integrity.

Parameters:
NUM_VECTORS, 64, vectors per run (2..65535)
SETTLE_CYCLES, 2, cycles between driving stim and sampling responses (0..15)
ERR_W, 8, width of err_count (saturating)
LFSR_SEED, 8'hA5, LFSR value loaded at reset and at each start (must be nonzero)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle run request; ignored while busy
stim  output  1  drives DUT data input
dut_out  input  1  DUT inverted output
dut_tie  input  1  DUT tie-high output
dut_misaligned  input  1  DUT off-grid tie-high output
busy  output  1  high from first DRIVE through last CHECK
done  output  1  high in DONE until next start
pass  output  1  valid while done; 1 iff err_count==0
err_count  output  ERR_W  failing vectors, saturates at all-ones
first_fail  output  16  index of first failing vector; 16'hFFFF if none

Behaviour:
- Reset (async assert, sync release) forces:
  - state=IDLE, stim=0, busy=0, done=0, pass=0, err_count=0, first_fail=16'hFFFF
  - vec_idx=0, settle_cnt=0, lfsr=LFSR_SEED.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Shifts left; feedback = lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3] enters bit 0. Advances only in CHECK.
- States: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE/DONE, start=1:
  - Clear err_count, done, pass; set first_fail=16'hFFFF, vec_idx=0, lfsr=LFSR_SEED.
  - Go to DRIVE.
- DRIVE (1 cycle):
  - stim <= lfsr[0]; settle_cnt <= SETTLE_CYCLES.
  - Go to CHECK if SETTLE_CYCLES==0, else SETTLE.
- SETTLE: settle_cnt decrements each cycle. Go to CHECK in the cycle it reaches 1, so SETTLE lasts exactly SETTLE_CYCLES cycles.
- CHECK (1 cycle):
  - fail = (dut_out == stim) | ~dut_tie | ~dut_misaligned.
  - If fail: err_count increments unless all-ones. If first_fail==16'hFFFF, first_fail <= vec_idx.
  - Advance lfsr.
  - If vec_idx==NUM_VECTORS-1: go to DONE, done<=1, pass<=(no errors including this vector).
  - Else: vec_idx++, go to DRIVE.
- Holds: stim holds its value through SETTLE and CHECK and keeps the last value in DONE. Responses are sampled only in CHECK.
- Timing:
  - Per-vector period = SETTLE_CYCLES+2 cycles.
  - done rises NUM_VECTORS*(SETTLE_CYCLES+2)+1 edges after the edge that samples start (defaults: 257).
- busy = state in {DRIVE, SETTLE, CHECK}, registered with the state.
- start while busy: ignored, no effect on counters.
- start in DONE: immediate restart; done drops the next cycle.
- Reset mid-run: abort immediately to reset values; no partial result retained.
- Inputs dut_* are in the clk domain; no synchronisers. The settle interval covers DUT propagation.

Test Plan:
- Ideal DUT model (out=~stim, ties=1), defaults, start pulse:
  - busy high 256 cycles; done at edge 257; pass=1, err_count=0, first_fail=16'hFFFF.
  - First stim value = 1 (seed bit0).
- dut_tie forced 0, defaults:
  - err_count=64, first_fail=0, pass=0.
  - Rerun with ERR_W=4: err_count=15 (saturation).
- dut_out = stim (non-inverting fault):
  - Every vector fails; err_count=64, first_fail=0.
- dut_misaligned pulsed 0 only during vector 10's CHECK:
  - err_count=1, first_fail=10, pass=0.
- SETTLE_CYCLES=0, ideal DUT: done at edge 129.
  - Extra start pulses while busy change nothing.
  - start in DONE restarts with cleared counters.
- Ideal DUT: assert rst_n=0 at vector 30:
  - Next cycle stim=0, busy=0, err_count=0, first_fail=16'hFFFF.
  - After release, a new start gives a full 257-cycle run with pass=1.

Source files
------------

// File: rtl/def_test_stim_checker.sv
// LFSR-driven stimulus/response checker for the pin-test design: drives one data pin
// and verifies the inverted output plus both tie-high pins after a settle interval.
module def_test_stim_checker #(
  parameter int unsigned NUM_VECTORS   = 64,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_W         = 8,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             stim,
  input  logic             dut_out,
  input  logic             dut_tie,
  input  logic             dut_misaligned,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [15:0]      first_fail
);

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_e;

  localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE_CYCLES);
  localparam logic [15:0]      LAST_IDX    = 16'(NUM_VECTORS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;
  localparam logic [15:0]      NO_FAIL     = 16'hFFFF;

  state_e           state_q, state_d;
  logic             start_q;
  logic             stim_q, stim_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [15:0]      first_q, first_d;
  logic [15:0]      vec_q, vec_d;
  logic [3:0]       settle_q, settle_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic             fail;
  logic [7:0]       lfsr_next;

  assign fail      = (dut_out == stim_q) | ~dut_tie | ~dut_misaligned;
  assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_comb begin
    state_d  = state_q;
    stim_d   = stim_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    first_d  = first_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    lfsr_d   = lfsr_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start_q) begin
          err_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          first_d = NO_FAIL;
          vec_d   = '0;
          lfsr_d  = LFSR_SEED;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        stim_d   = lfsr_q[0];
        settle_d = SETTLE_INIT;
        state_d  = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
      end
      SETTLE: begin
        settle_d = settle_q - 4'd1;
        if (settle_q <= 4'd1) state_d = CHECK;
      end
      CHECK: begin
        if (fail) begin
          if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
          if (first_q == NO_FAIL) first_d = vec_q;
        end
        lfsr_d = lfsr_next;
        if (vec_q == LAST_IDX) begin
          state_d = DONE;
          done_d  = 1'b1;
          // A saturated counter never wraps to zero, so err_q==0 means no earlier failure.
          pass_d  = (err_q == '0) && !fail;
        end else begin
          vec_d   = vec_q + 16'd1;
          state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == DRIVE) || (state_d == SETTLE) || (state_d == CHECK);
  end

  // start is captured first, so the run begins one edge after it is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      start_q  <= 1'b0;
      stim_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      first_q  <= NO_FAIL;
      vec_q    <= '0;
      settle_q <= '0;
      lfsr_q   <= LFSR_SEED;
    end else begin
      state_q  <= state_d;
      start_q  <= start;
      stim_q   <= stim_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      first_q  <= first_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      lfsr_q   <= lfsr_d;
    end
  end

  assign stim       = stim_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = first_q;

endmodule
